// File: rtl/shader_sequencer_if.sv
// Bundle of all non-clock/reset signals between the shader sequencer and its
// voxel memory, palette memory, shader core, framebuffer and controller.
interface shader_sequencer_if #(
    parameter int ROW_BITS      = 8,
    parameter int COL_BITS      = 8,
    parameter int COORD_BITS    = 8,
    parameter int PALETTE_BITS  = 8,
    parameter int PIXEL_BITS    = 8,
    parameter int VOX_ADDR_BITS = 10
);
    // Frame control and status
    logic                                  start;
    logic [VOX_ADDR_BITS-1:0]              voxel_count;
    logic                                  busy;
    logic                                  frame_done;

    // Voxel and palette memories; read data arrives the cycle after the strobe
    logic                                  vox_rd;
    logic [VOX_ADDR_BITS-1:0]              vox_addr;
    logic [3*COORD_BITS+PALETTE_BITS-1:0]  vox_rdata;
    logic                                  pal_rd;
    logic [PALETTE_BITS-1:0]               pal_addr;
    logic [PIXEL_BITS-1:0]                 pal_rdata;

    // Shader core
    logic                                  do_rasterize;
    logic                                  do_shade;
    logic [COORD_BITS-1:0]                 voxel_x;
    logic [COORD_BITS-1:0]                 voxel_y;
    logic [COORD_BITS-1:0]                 voxel_z;
    logic [PALETTE_BITS-1:0]               voxel_id;
    logic [PIXEL_BITS-1:0]                 palette_entry;
    logic [ROW_BITS-1:0]                   row;
    logic [COL_BITS-1:0]                   col;
    logic                                  rasterizing_done;
    logic                                  shading_done;
    logic [PIXEL_BITS-1:0]                 pixel;

    // Framebuffer write port
    logic                                  fb_we;
    logic [ROW_BITS-1:0]                   fb_row;
    logic [COL_BITS-1:0]                   fb_col;
    logic [PIXEL_BITS-1:0]                 fb_data;

    modport master (
        input  start, voxel_count, vox_rdata, pal_rdata,
               rasterizing_done, shading_done, pixel,
        output busy, frame_done, vox_rd, vox_addr, pal_rd, pal_addr,
               do_rasterize, do_shade, voxel_x, voxel_y, voxel_z, voxel_id,
               palette_entry, row, col, fb_we, fb_row, fb_col, fb_data
    );

    modport slave (
        output start, voxel_count, vox_rdata, pal_rdata,
               rasterizing_done, shading_done, pixel,
        input  busy, frame_done, vox_rd, vox_addr, pal_rd, pal_addr,
               do_rasterize, do_shade, voxel_x, voxel_y, voxel_z, voxel_id,
               palette_entry, row, col, fb_we, fb_row, fb_col, fb_data
    );
endinterface

// File: rtl/shader_sequencer.sv
// Walks every pixel of the frame, feeding each voxel and its palette entry to
// the rasterizer, then shading the pixel and writing it to the framebuffer.
module shader_sequencer #(
    parameter int ROW_BITS      = 8,
    parameter int COL_BITS      = 8,
    parameter int COORD_BITS    = 8,
    parameter int PALETTE_BITS  = 8,
    parameter int PIXEL_BITS    = 8,
    parameter int VOX_ADDR_BITS = 10,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4
) (
    input  logic                clock,
    input  logic                reset,
    shader_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, VFETCH, PFETCH, LOAD, RASTER, SHADE, WRITE, DONE
    } state_t;

    localparam logic [ROW_BITS-1:0]      LAST_ROW = ROW_BITS'(NUM_ROWS - 1);
    localparam logic [COL_BITS-1:0]      LAST_COL = COL_BITS'(NUM_COLS - 1);
    localparam logic [VOX_ADDR_BITS-1:0] VOX_ONE  = VOX_ADDR_BITS'(1);

    state_t                   state, next;
    logic [VOX_ADDR_BITS-1:0] count_q;
    logic [VOX_ADDR_BITS-1:0] v_q;
    logic [ROW_BITS-1:0]      row_q;
    logic [COL_BITS-1:0]      col_q;
    logic [COORD_BITS-1:0]    vx_q, vy_q, vz_q;
    logic [PALETTE_BITS-1:0]  vid_q;
    logic [PIXEL_BITS-1:0]    pal_q;
    logic [PIXEL_BITS-1:0]    pix_q;

    logic [COORD_BITS-1:0]    rd_x, rd_y, rd_z;
    logic [PALETTE_BITS-1:0]  rd_id;
    logic                     last_pixel, last_voxel, has_voxels;

    // vox_rdata is packed {x, y, z, id} with id in the low bits
    assign rd_id = bus.vox_rdata[PALETTE_BITS-1:0];
    assign rd_z  = bus.vox_rdata[PALETTE_BITS +: COORD_BITS];
    assign rd_y  = bus.vox_rdata[PALETTE_BITS+COORD_BITS +: COORD_BITS];
    assign rd_x  = bus.vox_rdata[PALETTE_BITS+2*COORD_BITS +: COORD_BITS];

    assign last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign last_voxel = (v_q == count_q - VOX_ONE);
    assign has_voxels = (count_q != '0);

    assign bus.voxel_x       = vx_q;
    assign bus.voxel_y       = vy_q;
    assign bus.voxel_z       = vz_q;
    assign bus.voxel_id      = vid_q;
    assign bus.palette_entry = pal_q;
    assign bus.row           = row_q;
    assign bus.col           = col_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next             = state;
        bus.vox_rd       = 1'b0;
        bus.vox_addr     = '0;
        bus.pal_rd       = 1'b0;
        bus.pal_addr     = '0;
        bus.do_rasterize = 1'b0;
        bus.do_shade     = 1'b0;
        bus.fb_we        = 1'b0;
        bus.fb_row       = '0;
        bus.fb_col       = '0;
        bus.fb_data      = '0;
        bus.frame_done   = 1'b0;
        bus.busy         = (state != IDLE);
        case (state)
            IDLE: begin
                // An empty voxel list skips straight to writing black pixels
                if (bus.start) next = (bus.voxel_count != '0) ? VFETCH : WRITE;
            end
            VFETCH: begin
                bus.vox_rd   = 1'b1;
                bus.vox_addr = v_q;
                next         = PFETCH;
            end
            PFETCH: begin
                bus.pal_rd   = 1'b1;
                bus.pal_addr = rd_id;
                next         = LOAD;
            end
            LOAD: next = RASTER;
            RASTER: begin
                bus.do_rasterize = 1'b1;
                if (bus.rasterizing_done) next = last_voxel ? SHADE : VFETCH;
            end
            SHADE: begin
                bus.do_shade = 1'b1;
                if (bus.shading_done) next = WRITE;
            end
            WRITE: begin
                bus.fb_we   = 1'b1;
                bus.fb_row  = row_q;
                bus.fb_col  = col_q;
                bus.fb_data = pix_q;
                if (last_pixel)      next = DONE;
                else if (has_voxels) next = VFETCH;
                else                 next = WRITE;
            end
            DONE: begin
                bus.frame_done = 1'b1;
                next           = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            v_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vz_q    <= '0;
            vid_q   <= '0;
            pal_q   <= '0;
            pix_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count_q <= bus.voxel_count;
                        v_q     <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        pix_q   <= '0;
                    end
                end
                PFETCH: begin
                    vx_q  <= rd_x;
                    vy_q  <= rd_y;
                    vz_q  <= rd_z;
                    vid_q <= rd_id;
                end
                LOAD:   pal_q <= bus.pal_rdata;
                RASTER: if (bus.rasterizing_done) v_q <= v_q + VOX_ONE;
                SHADE:  if (bus.shading_done) pix_q <= bus.pixel;
                WRITE: begin
                    v_q <= '0;
                    // Position holds on the final pixel so row/col stay in range
                    if (!last_pixel) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_BITS'(1);
                        end else begin
                            col_q <= col_q + COL_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
